uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20'd1000000, WAIT_DONE watchdog limit in clk cycles; used only when UART_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 byte pending; level, held until ack0.
REQ-005 data0  input  8  requester 0 byte; stable while req0 high.
REQ-006 req1  input  1  requester 1 byte pending; level, held until ack1.
REQ-007 data1  input  8  requester 1 byte; stable while req1 high.
REQ-008 ack0  output  1  one-cycle pulse: data0 captured.
REQ-009 ack1  output  1  one-cycle pulse: data1 captured.
REQ-010 tx_send  output  1  one-cycle active-high start pulse to transmitter.
REQ-011 tx_data  output  8  registered byte presented to transmitter.
REQ-012 tx_active  input  1  transmitter frame in progress.
REQ-013 tx_done  input  1  transmitter frame complete; level or pulse.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 last_grant  output  1  index of last requester served.
REQ-016 timeout_err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-017 FSM states IDLE, SEND, WAIT_DONE, GAP; encoding free.
REQ-018 IDLE, no req: remain in IDLE; all outputs hold.
REQ-019 IDLE, exactly one req high: grant it on next edge.
REQ-020 IDLE, both req high: grant ~last_grant (round-robin).
REQ-021 Grant edge: tx_data <= selected data, ackN <= 1 for one cycle, last_grant <= N, state <= SEND.
REQ-022 SEND: tx_send high exactly this one cycle; next state WAIT_DONE.
REQ-023 Latency: req sampled at edge k -> ack and tx_data valid cycle k+1, tx_send high cycle k+2.
REQ-024 WAIT_DONE: detect rising edge of tx_done via registered previous sample; on edge -> GAP.
REQ-025 tx_done already high on WAIT_DONE entry is not a completion; a fresh 0->1 transition is required.
REQ-026 GAP: one cycle, no grant; then IDLE, so back-to-back requests produce idle cycles between tx_send pulses.
REQ-027 tx_data holds the granted byte from grant until the next grant.
REQ-028 req deasserted after ack has no effect on the frame in flight.
REQ-029 tx_active is status only: no transitions depend on it; it is used for the watchdog clear.

Reset
REQ-030 reset_n low: state IDLE; ack0, ack1, tx_send, busy, timeout_err = 0; tx_data = 8'h00; last_grant = 1 (requester 0 wins first tie); done edge register = 0; watchdog = 0.
REQ-031 Reset mid-frame aborts immediately; no ack or tx_send is emitted until a new grant after release.

Configuration
REQ-032 Macro UART_ARB_TIMEOUT_EN defined: counter runs in WAIT_DONE and clears while tx_active rises.
REQ-033 With the macro, reaching TIMEOUT_CYCLES without a done edge pulses timeout_err for one cycle and forces IDLE; last_grant is kept.
REQ-034 Macro undefined: no counter logic; timeout_err tied 0; WAIT_DONE waits indefinitely.

Verification
REQ-035 req0=1, data0=8'hA5 at edge k -> ack0 at k+1, tx_data=8'hA5, tx_send pulse at k+2, busy=1 from k+1.
REQ-036 req0 and req1 both high after reset -> req0 served first, then req1 after its done edge; ack order 0,1,0,1 while both are held.
REQ-037 tx_done held high across entry to WAIT_DONE -> no exit until tx_done falls then rises; one GAP cycle, then IDLE.
REQ-038 reset_n low during WAIT_DONE -> busy=0, tx_send=0, tx_data=8'h00 asynchronously; a pending req1 is granted normally after release.
REQ-039 Macro defined, TIMEOUT_CYCLES=16, tx_done stuck 0 -> timeout_err pulse 16 cycles after WAIT_DONE entry, then IDLE; macro undefined -> timeout_err stays 0 and busy stays 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds bytes from two requesters into one UART transmitter.
// Optional WAIT_DONE watchdog is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       tx_send,
  output logic [7:0] tx_data,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       busy,
  output logic       last_grant,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

  state_t     state_reg, state_next;
  logic [7:0] tx_data_reg;
  logic       ack0_reg, ack1_reg, tx_send_reg, last_grant_reg, done_prev_reg;
  logic       grant0, grant1, done_edge, timeout_hit;

  // Completion is a fresh 0->1 on tx_done; a level already high on entry is ignored.
  assign done_edge = tx_done & ~done_prev_reg;

`ifdef UART_ARB_TIMEOUT_EN
  logic [19:0] wd_cnt_reg;
  logic        active_prev_reg, timeout_err_reg, active_rise;

  assign active_rise = tx_active & ~active_prev_reg;
  assign timeout_hit = (state_reg == WAIT_DONE) && !active_rise &&
                       (wd_cnt_reg == TIMEOUT_CYCLES - 20'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_reg      <= '0;
      active_prev_reg <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      active_prev_reg <= tx_active;
      timeout_err_reg <= timeout_hit && !done_edge;
      if (state_reg != WAIT_DONE || active_rise || timeout_hit)
        wd_cnt_reg <= '0;
      else
        wd_cnt_reg <= wd_cnt_reg + 20'd1;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{tx_active, TIMEOUT_CYCLES};
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state_reg)
      IDLE: begin
        // On a tie the requester not served last time wins.
        if (req0 && (!req1 || last_grant_reg)) begin
          grant0     = 1'b1;
          state_next = SEND;
        end else if (req1) begin
          grant1     = 1'b1;
          state_next = SEND;
        end
      end
      SEND:      state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (done_edge)
          state_next = GAP;
        else if (timeout_hit)
          state_next = IDLE;
      end
      GAP:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      tx_data_reg    <= 8'h00;
      ack0_reg       <= 1'b0;
      ack1_reg       <= 1'b0;
      tx_send_reg    <= 1'b0;
      last_grant_reg <= 1'b1;
      done_prev_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      done_prev_reg <= tx_done;
      ack0_reg      <= grant0;
      ack1_reg      <= grant1;
      // Start pulse lands one cycle after the ack, while the FSM leaves SEND.
      tx_send_reg   <= (state_reg == SEND);
      if (grant0) begin
        tx_data_reg    <= data0;
        last_grant_reg <= 1'b0;
      end else if (grant1) begin
        tx_data_reg    <= data1;
        last_grant_reg <= 1'b1;
      end
    end
  end

  assign ack0       = ack0_reg;
  assign ack1       = ack1_reg;
  assign tx_send    = tx_send_reg;
  assign tx_data    = tx_data_reg;
  assign busy       = (state_reg != IDLE);
  assign last_grant = last_grant_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames against a
// transaction-level round-robin model. Builds with or without UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, tx_active = 1'b0, tx_done = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, tx_send, busy, last_grant, timeout_err;
  logic [7:0] tx_data;
  int         checks = 0, errors = 0;
  logic       lg_model = 1'b1;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(20'd16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .tx_send(tx_send), .tx_data(tx_data),
    .tx_active(tx_active), .tx_done(tx_done),
    .busy(busy), .last_grant(last_grant), .timeout_err(timeout_err)
  );

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; tx_done = 1'b0; tx_active = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lg_model = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ack0, ack1, tx_send, busy, timeout_err, last_grant} !== 6'b000001 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got ack0/ack1/send/busy/terr/lg=%b%b%b%b%b%b tx_data=%h exp 000001 00",
               ack0, ack1, tx_send, busy, timeout_err, last_grant, tx_data);
    end
    reset_n = 1'b1;
    lg_model = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack0, ack1, tx_send, busy, last_grant} !== 5'b00001 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL idle_hold got ack0/ack1/send/busy/lg=%b%b%b%b%b tx_data=%h exp 00001 00",
               ack0, ack1, tx_send, busy, last_grant, tx_data);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_single(input logic [7:0] d);
    @(negedge clk); req0 = 1'b1; data0 = d;
    @(negedge clk);
    checks++;
    if ({ack0, ack1, busy, tx_send} !== 4'b1010 || tx_data !== d) begin
      errors++;
      $display("FAIL single_grant got ack0/ack1/busy/send=%b%b%b%b tx_data=%h exp 1010 %h",
               ack0, ack1, busy, tx_send, tx_data, d);
    end
    lg_model = 1'b0;
    req0 = 1'b0; data0 = ~d;
    @(negedge clk);
    checks++;
    if ({ack0, ack1, busy, tx_send, last_grant} !== 5'b00110 || tx_data !== d) begin
      errors++;
      $display("FAIL single_send got ack0/ack1/busy/send/lg=%b%b%b%b%b tx_data=%h exp 00110 %h",
               ack0, ack1, busy, tx_send, last_grant, tx_data, d);
    end
    @(negedge clk);
    checks++;
    if ({busy, tx_send} !== 2'b10) begin
      errors++;
      $display("FAIL single_wait got busy/send=%b%b exp 10", busy, tx_send);
    end
    tx_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, tx_send} !== 2'b10) begin
      errors++;
      $display("FAIL single_gap got busy/send=%b%b exp 10", busy, tx_send);
    end
    tx_done = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_data !== d) begin
      errors++;
      $display("FAIL single_idle got busy=%b tx_data=%h exp 0 %h", busy, tx_data, d);
    end
    $display("single: byte %h sent by requester 0", d);
  endtask

  task automatic test_round_robin();
    logic [7:0] d0, d1, exp_d;
    logic       idx;
    int         waited, exp_wait;
    do_reset();
    d0 = 8'($urandom); d1 = 8'($urandom);
    req0 = 1'b1; req1 = 1'b1; data0 = d0; data1 = d1;
    for (int k = 0; k < 4; k++) begin
      idx = ~lg_model;
      exp_d = idx ? d1 : d0;
      exp_wait = (k == 0) ? 1 : 2;
      waited = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk); waited++;
        if (ack0 || ack1) break;
      end
      checks++;
      if (waited !== exp_wait || {ack0, ack1} !== (idx ? 2'b01 : 2'b10) || tx_data !== exp_d) begin
        errors++;
        $display("FAIL rr_grant%0d got wait=%0d ack0/ack1=%b%b tx_data=%h exp wait=%0d idx=%0d %h",
                 k, waited, ack0, ack1, tx_data, exp_wait, idx, exp_d);
      end
      lg_model = idx;
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      checks++;
      if (tx_send !== 1'b1 || last_grant !== idx) begin
        errors++;
        $display("FAIL rr_send%0d got send=%b lg=%b exp 1 %b", k, tx_send, last_grant, idx);
      end
      $display("round_robin: frame %0d granted requester %0d byte %h", k, idx, tx_data);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_done_held();
    logic [7:0] d;
    int         busy_low;
    d = 8'($urandom);
    tx_done = 1'b1;
    req1 = 1'b1; data1 = d;
    @(negedge clk);
    checks++;
    if ({ack0, ack1} !== 2'b01 || tx_data !== d) begin
      errors++;
      $display("FAIL held_grant got ack0/ack1=%b%b tx_data=%h exp 01 %h", ack0, ack1, tx_data, d);
    end
    lg_model = 1'b1;
    req1 = 1'b0;
    @(negedge clk);
    busy_low = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
    end
    tx_done = 1'b0;
    @(negedge clk);
    if (busy !== 1'b1) busy_low++;
    checks++;
    if (busy_low !== 0) begin
      errors++;
      $display("FAIL held_no_exit got %0d cycles with busy low exp 0", busy_low);
    end
    tx_done = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_gap got busy=%b exp 1", busy);
    end
    tx_done = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_idle got busy=%b exp 0", busy);
    end
    $display("done_held: byte %h completed only after fresh tx_done edge", d);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d0, d1;
    d0 = 8'($urandom) | 8'h01; d1 = 8'($urandom);
    req0 = 1'b1; data0 = d0;
    @(negedge clk);
    lg_model = 1'b0;
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    req1 = 1'b1; data1 = d1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, tx_send, ack0, ack1, last_grant} !== 5'b00001 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got busy/send/ack0/ack1/lg=%b%b%b%b%b tx_data=%h exp 00001 00",
               busy, tx_send, ack0, ack1, last_grant, tx_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    lg_model = 1'b1;
    @(negedge clk);
    checks++;
    if ({ack0, ack1} !== 2'b01 || tx_data !== d1 || last_grant !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant got ack0/ack1=%b%b tx_data=%h lg=%b exp 01 %h 1",
               ack0, ack1, tx_data, last_grant, d1);
    end
    req1 = 1'b0;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    $display("reset_mid: frame aborted, pending byte %h granted after release", d1);
  endtask

  task automatic test_timeout();
    int bad;
    req0 = 1'b1; data0 = 8'($urandom);
    @(negedge clk);
    lg_model = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int n = 1; n < 16; n++) begin
      @(negedge clk);
      if ({busy, timeout_err} !== 2'b10) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL timeout_early got %0d cycles not busy/quiet exp 0", bad);
    end
    @(negedge clk);
`ifdef UART_ARB_TIMEOUT_EN
    checks++;
    if ({timeout_err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_fire got terr/busy=%b%b exp 10", timeout_err, busy);
    end
    @(negedge clk);
    checks++;
    if ({timeout_err, busy, last_grant} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_after got terr/busy/lg=%b%b%b exp 000", timeout_err, busy, last_grant);
    end
    $display("timeout: watchdog fired after 16 cycles");
`else
    checks++;
    if ({timeout_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_off got terr/busy=%b%b exp 01", timeout_err, busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({timeout_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_off_hold got terr/busy=%b%b exp 01", timeout_err, busy);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    $display("timeout: no watchdog, waited for tx_done");
`endif
  endtask

  task automatic test_random();
    logic [1:0] p;
    logic [7:0] d0, d1, exp_d;
    logic       idx;
    int         bad, w, g;
    for (int t = 0; t < 24; t++) begin
      g = $urandom_range(0, 2);
      bad = 0;
      for (int i = 0; i < g; i++) begin
        @(negedge clk);
        if ({busy, ack0, ack1, tx_send} !== 4'b0000) bad++;
      end
      p = 2'($urandom_range(1, 3));
      d0 = 8'($urandom); d1 = 8'($urandom);
      idx = (p == 2'b11) ? ~lg_model : p[1];
      exp_d = idx ? d1 : d0;
      req0 = p[0]; req1 = p[1]; data0 = d0; data1 = d1;
      @(negedge clk);
      checks++;
      if ({ack0, ack1} !== (idx ? 2'b01 : 2'b10) || tx_data !== exp_d || last_grant !== idx || bad !== 0) begin
        errors++;
        $display("FAIL rand_grant%0d got ack0/ack1=%b%b tx_data=%h lg=%b idlebad=%0d exp idx=%0d %h",
                 t, ack0, ack1, tx_data, last_grant, bad, idx, exp_d);
      end
      lg_model = idx;
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      checks++;
      if ({tx_send, ack0, ack1} !== 3'b100) begin
        errors++;
        $display("FAIL rand_send%0d got send/ack0/ack1=%b%b%b exp 100", t, tx_send, ack0, ack1);
      end
      tx_active = 1'b1;
      w = $urandom_range(0, 5);
      bad = 0;
      for (int i = 0; i < w; i++) begin
        @(negedge clk);
        if ({busy, tx_send} !== 2'b10 || tx_data !== exp_d) bad++;
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0; tx_active = 1'b0;
      if (busy !== 1'b1) bad++;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bad !== 0 || tx_data !== exp_d) begin
        errors++;
        $display("FAIL rand_frame%0d got busy=%b bad=%0d tx_data=%h exp 0 0 %h", t, busy, bad, tx_data, exp_d);
      end
      $display("random: frame %0d pattern %b granted %0d byte %h wait %0d", t, p, idx, exp_d, w);
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_single(8'($urandom));
    test_round_robin();
    test_done_held();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
